// File: rtl/aqp_ovl_console.sv
// Overlay console: turns an accepted byte stream into {attr, char} writes to the
// overlay text RAM, tracking a COLS x ROWS cursor and handling a small set of
// control codes (CR, LF, BS, FF). Reset triggers a clear of the full 1024-word RAM.
module aqp_ovl_console #(
  parameter int          COLS         = 40,
  parameter int          ROWS         = 25,
  parameter logic [7:0]  DEFAULT_ATTR = 8'hF0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  input  logic        clear_req,
  output logic        busy,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [9:0]  ovl_text_addr,
  output logic [15:0] ovl_text_wrdata,
  output logic        ovl_text_wr
);

  localparam logic [5:0]  LAST_X  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_Y  = 5'(ROWS - 1);
  localparam logic [9:0]  STRIDE  = 10'(COLS);
  // Clear counters run one past the last address; that extra cycle drops wr
  // before the block reopens, so in_ready rises only after the final write.
  localparam logic [10:0] SCR_END = 11'(COLS * ROWS);
  localparam logic [10:0] ALL_END = 11'd1024;

  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_CLR_SCR = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [10:0] cnt_reg, cnt_next;
  logic [5:0]  x_reg, x_next;
  logic [4:0]  y_reg, y_next;
  logic [9:0]  row_base_reg, row_base_next;   // y*COLS kept incrementally
  logic [7:0]  attr_lat_reg, attr_lat_next;
  logic        wr_reg, wr_next;
  logic [9:0]  addr_reg, addr_next;
  logic [15:0] data_reg, data_next;

  logic [9:0]  cell_addr;
  logic [4:0]  y_inc;
  logic [9:0]  row_base_inc;

  assign cell_addr    = row_base_reg + {4'd0, x_reg};
  assign y_inc        = (y_reg == LAST_Y) ? 5'd0  : y_reg + 5'd1;
  assign row_base_inc = (y_reg == LAST_Y) ? 10'd0 : row_base_reg + STRIDE;

  assign in_ready        = (state_reg == ST_IDLE) && !clear_req;
  assign busy            = (state_reg != ST_IDLE);
  assign cursor_x        = x_reg;
  assign cursor_y        = y_reg;
  assign ovl_text_addr   = addr_reg;
  assign ovl_text_wrdata = data_reg;
  assign ovl_text_wr     = wr_reg;

  // State and output registers; reset aborts any clear or stream in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_CLR_ALL;
      cnt_reg      <= 11'd0;
      x_reg        <= 6'd0;
      y_reg        <= 5'd0;
      row_base_reg <= 10'd0;
      attr_lat_reg <= 8'd0;
      wr_reg       <= 1'b0;
      addr_reg     <= 10'd0;
      data_reg     <= 16'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      row_base_reg <= row_base_next;
      attr_lat_reg <= attr_lat_next;
      wr_reg       <= wr_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
    end
  end

  // Next-state logic: clear sequencing and byte decode.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    row_base_next = row_base_reg;
    attr_lat_next = attr_lat_reg;
    wr_next       = 1'b0;
    addr_next     = addr_reg;
    data_next     = data_reg;

    case (state_reg)
      ST_CLR_ALL: begin
        if (cnt_reg == ALL_END) begin
          state_next = ST_IDLE;
          cnt_next   = 11'd0;
        end else begin
          wr_next   = 1'b1;
          addr_next = cnt_reg[9:0];
          data_next = {DEFAULT_ATTR, 8'h20};
          cnt_next  = cnt_reg + 11'd1;
        end
      end

      ST_CLR_SCR: begin
        if (cnt_reg == SCR_END) begin
          state_next = ST_IDLE;
          cnt_next   = 11'd0;
        end else begin
          wr_next   = 1'b1;
          addr_next = cnt_reg[9:0];
          data_next = {attr_lat_reg, 8'h20};
          cnt_next  = cnt_reg + 11'd1;
        end
      end

      ST_IDLE: begin
        // clear_req wins over a simultaneous byte, which then stays pending.
        if (clear_req || (in_valid && in_data == 8'h0C)) begin
          state_next    = ST_CLR_SCR;
          cnt_next      = 11'd0;
          attr_lat_next = attr;
          x_next        = 6'd0;
          y_next        = 5'd0;
          row_base_next = 10'd0;
        end else if (in_valid) begin
          if (in_data >= 8'h20) begin
            wr_next   = 1'b1;
            addr_next = cell_addr;
            data_next = {attr, in_data};
            if (x_reg == LAST_X) begin
              x_next        = 6'd0;
              y_next        = y_inc;
              row_base_next = row_base_inc;
            end else begin
              x_next = x_reg + 6'd1;
            end
          end else if (in_data == 8'h0D) begin
            x_next = 6'd0;
          end else if (in_data == 8'h0A) begin
            y_next        = y_inc;
            row_base_next = row_base_inc;
          end else if (in_data == 8'h08) begin
            // Stepping back one cell is always cell-1, except at the origin.
            wr_next   = 1'b1;
            data_next = {attr, 8'h20};
            addr_next = (cell_addr == 10'd0) ? 10'd0 : cell_addr - 10'd1;
            if (x_reg != 6'd0) begin
              x_next = x_reg - 6'd1;
            end else if (y_reg != 5'd0) begin
              x_next        = LAST_X;
              y_next        = y_reg - 5'd1;
              row_base_next = row_base_reg - STRIDE;
            end
          end
        end
      end

      default: begin
        state_next = ST_CLR_ALL;
        cnt_next   = 11'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_aqp_ovl_console.sv
// Self-checking bench for aqp_ovl_console: directed table, clear/reset sequences
// and a randomized byte stream checked against a cursor/write model.
module tb_aqp_ovl_console;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  logic        clear_req;
  logic        busy;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [9:0]  ovl_text_addr;
  logic [15:0] ovl_text_wrdata;
  logic        ovl_text_wr;

  aqp_ovl_console dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .attr            (attr),
    .clear_req       (clear_req),
    .busy            (busy),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .ovl_text_addr   (ovl_text_addr),
    .ovl_text_wrdata (ovl_text_wrdata),
    .ovl_text_wr     (ovl_text_wr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          exp_x = 0;
  int          exp_y = 0;
  logic        ew;
  logic [9:0]  eaddr;
  logic [15:0] edata;
  logic        eclr;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  a;
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [5:0]  x;
    logic [4:0]  y;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Screen model: cursor arithmetic straight from the byte rules.
  task automatic step(input logic [7:0] b, input logic [7:0] a);
    ew = 1'b0; eclr = 1'b0; eaddr = '0; edata = '0;
    if (b == 8'h0C) begin
      exp_x = 0; exp_y = 0; eclr = 1'b1;
    end else if (b >= 8'h20) begin
      ew = 1'b1; eaddr = 10'(exp_y * 40 + exp_x); edata = {a, b};
      exp_x++;
      if (exp_x == 40) begin exp_x = 0; exp_y = (exp_y + 1) % 25; end
    end else if (b == 8'h0D) begin
      exp_x = 0;
    end else if (b == 8'h0A) begin
      exp_y = (exp_y + 1) % 25;
    end else if (b == 8'h08) begin
      if (exp_x > 0) exp_x--;
      else if (exp_y > 0) begin exp_x = 39; exp_y--; end
      ew = 1'b1; eaddr = 10'(exp_y * 40 + exp_x); edata = {a, 8'h20};
    end
  endtask

  // Called at a falling edge with the block idle; leaves in_valid low afterwards
  // but in the same timestep, so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] b, input logic [7:0] a);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = b; attr = a;
    step(b, a);
    @(negedge clk);
    in_valid = 1'b0;
    chk("wr", ovl_text_wr, ew);
    if (ew) begin
      chk("addr", ovl_text_addr, eaddr);
      chk("data", ovl_text_wrdata, edata);
    end
    chk("cursor_x", cursor_x, exp_x);
    chk("cursor_y", cursor_y, exp_y);
    if (eclr) chk("busy_ff", busy, 1);
  endtask

  task automatic clear_check(input int n, input logic [15:0] word);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("clr_wr", ovl_text_wr, 1);
      chk("clr_addr", ovl_text_addr, i);
      chk("clr_data", ovl_text_wrdata, word);
      chk("clr_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("clr_end_wr", ovl_text_wr, 0);
    chk("clr_end_ready", in_ready, 1);
    chk("clr_end_busy", busy, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr", ovl_text_wr, 0);
    chk("rst_addr", ovl_text_addr, 0);
    chk("rst_data", ovl_text_wrdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_x", cursor_x, 0);
    chk("rst_y", cursor_y, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;

    //       byte   attr   wr    addr     data       x      y
    tbl[0]  = '{8'h08, 8'h1E, 1'b1, 10'd0,   16'h1E20, 6'd0,  5'd0}; // BS from (1,0)
    tbl[1]  = '{8'h41, 8'h1E, 1'b1, 10'd0,   16'h1E41, 6'd1,  5'd0};
    tbl[2]  = '{8'h42, 8'h1E, 1'b1, 10'd1,   16'h1E42, 6'd2,  5'd0};
    tbl[3]  = '{8'h0D, 8'h1E, 1'b0, 10'd0,   16'h0000, 6'd0,  5'd0};
    tbl[4]  = '{8'h08, 8'h1E, 1'b1, 10'd0,   16'h1E20, 6'd0,  5'd0}; // BS at origin
    tbl[5]  = '{8'h0A, 8'h1E, 1'b0, 10'd0,   16'h0000, 6'd0,  5'd1};
    tbl[6]  = '{8'h0A, 8'h1E, 1'b0, 10'd0,   16'h0000, 6'd0,  5'd2};
    tbl[7]  = '{8'h0A, 8'h1E, 1'b0, 10'd0,   16'h0000, 6'd0,  5'd3};
    tbl[8]  = '{8'h08, 8'h1E, 1'b1, 10'd119, 16'h1E20, 6'd39, 5'd2}; // BS at row start
    tbl[9]  = '{8'h01, 8'h1E, 1'b0, 10'd0,   16'h0000, 6'd39, 5'd2};
    tbl[10] = '{8'h63, 8'h33, 1'b1, 10'd119, 16'h3363, 6'd0,  5'd3};
    tbl[11] = '{8'h0A, 8'h33, 1'b0, 10'd0,   16'h0000, 6'd0,  5'd4};

    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'h51; attr = 8'h1E; clear_req = 1'b0;

    // Power-on clear with a byte already waiting
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset_n = 1'b1;
    clear_check(1024, 16'hF020);
    step(8'h51, 8'h1E);
    @(negedge clk);
    in_valid = 1'b0;
    chk("first_byte_wr", ovl_text_wr, 1);
    chk("first_byte_addr", ovl_text_addr, 0);
    chk("first_byte_data", ovl_text_wrdata, 16'h1E51);
    chk("first_byte_x", cursor_x, 1);

    // Directed table, streamed back-to-back
    foreach (tbl[i]) begin
      send(tbl[i].b, tbl[i].a);
      chk($sformatf("tbl%0d_wr", i), ovl_text_wr, tbl[i].wr);
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_addr", i), ovl_text_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_data", i), ovl_text_wrdata, tbl[i].data);
      end
      chk($sformatf("tbl%0d_x", i), cursor_x, tbl[i].x);
      chk($sformatf("tbl%0d_y", i), cursor_y, tbl[i].y);
    end

    // clear_req with a simultaneous byte: clear wins, byte waits
    clear_req = 1'b1; in_valid = 1'b1; in_data = 8'h4B; attr = 8'h52;
    #1;
    chk("creq_ready", in_ready, 0);
    @(negedge clk);
    clear_req = 1'b0;
    chk("creq_busy", busy, 1);
    chk("creq_wr", ovl_text_wr, 0);
    chk("creq_x", cursor_x, 0);
    chk("creq_y", cursor_y, 0);
    exp_x = 0; exp_y = 0;
    clear_check(1000, 16'h5220);
    step(8'h4B, 8'h52);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pending_wr", ovl_text_wr, 1);
    chk("pending_addr", ovl_text_addr, 0);
    chk("pending_data", ovl_text_wrdata, 16'h524B);

    // Line wrap and vertical wraparound
    send(8'h0D, 8'h1E);
    for (int i = 0; i < 40; i++) send(8'h61 + 8'(i % 26), 8'h1E);
    chk("wrap_last_addr", ovl_text_addr, 39);
    chk("wrap_x", cursor_x, 0);
    chk("wrap_y", cursor_y, 1);
    for (int i = 0; i < 25; i++) begin
      send(8'h0D, 8'h1E);
      send(8'h0A, 8'h1E);
    end
    chk("vwrap_y", cursor_y, 1);
    send(8'h5A, 8'h1E);
    chk("z_addr", ovl_text_addr, 40);
    chk("z_data", ovl_text_wrdata, 16'h1E5A);

    // Reset in the middle of a screen clear
    send(8'h0C, 8'h77);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      chk("mid_addr", ovl_text_addr, i);
    end
    #2 reset_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    exp_x = 0; exp_y = 0;
    clear_check(1024, 16'hF020);

    // Randomized stream against the model
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      b = 8'($urandom_range(8'h20, 8'hFF));
      else if (r < 68) b = 8'h0D;
      else if (r < 76) b = 8'h0A;
      else if (r < 88) b = 8'h08;
      else if (r < 98) b = 8'($urandom_range(0, 31));
      else             b = 8'h0C;
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        chk("gap_wr", ovl_text_wr, 0);
        chk("gap_x", cursor_x, exp_x);
      end
      send(b, 8'($urandom));
      if (eclr) clear_check(1000, {attr, 8'h20});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
